// File: rtl/rayid_pool_ctrl_pkg.sv
// Shared rayID types and pool defaults for the shader and rayid_pool_ctrl.
package rayid_pool_ctrl_pkg;

  localparam int unsigned NUM_RAYIDS             = 512;
  localparam int unsigned RAYID_W                = $clog2(NUM_RAYIDS);
  localparam int unsigned SHADOW_RESERVE_DEFAULT = 32;
  localparam int unsigned NUM_REL_DEFAULT        = 4;

  typedef logic [RAYID_W-1:0] rayID_t;

  typedef enum logic {
    INIT,
    RUN
  } pool_state_e;

endpackage

// File: rtl/rayid_pool_ctrl_if.sv
// rayID pool bus: two allocating requesters, NUM_REL release sources, status.
//   master : requester side (drives req, rel_valid, rel_id)
//   slave  : pool side (drives grants, ids, rel_stall, free_count, init_done, err_bad_free)
interface rayid_pool_ctrl_if
  import rayid_pool_ctrl_pkg::*;
#(
  parameter int unsigned ID_W    = RAYID_W,
  parameter int unsigned NUM_REL = NUM_REL_DEFAULT
);

  logic                           prim_req;
  logic                           prim_gnt;
  logic [ID_W-1:0]                prim_id;
  logic                           shd_req;
  logic                           shd_gnt;
  logic [ID_W-1:0]                shd_id;
  logic [NUM_REL-1:0]             rel_valid;
  logic [NUM_REL-1:0][ID_W-1:0]   rel_id;
  logic [NUM_REL-1:0]             rel_stall;
  logic [ID_W:0]                  free_count;
  logic                           init_done;
  logic                           err_bad_free;

  modport master (
    output prim_req, shd_req, rel_valid, rel_id,
    input  prim_gnt, prim_id, shd_gnt, shd_id, rel_stall,
           free_count, init_done, err_bad_free
  );

  modport slave (
    input  prim_req, shd_req, rel_valid, rel_id,
    output prim_gnt, prim_id, shd_gnt, shd_id, rel_stall,
           free_count, init_done, err_bad_free
  );

endinterface

// File: rtl/rayid_freelist.sv
// Circular free list of rayIDs, NUM_IDS x ID_W, show-ahead read.
//   wr_en/wr_data : push at tail (caller never pushes when full)
//   rd_en         : pop head (caller never pops when empty)
//   rd_data       : current head, '0 when empty
//   count         : entries held, 0..NUM_IDS
module rayid_freelist #(
  parameter int unsigned NUM_IDS = 512,
  parameter int unsigned ID_W    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_data,
  input  logic            rd_en,
  output logic [ID_W-1:0] rd_data,
  output logic [ID_W:0]   count
);

  logic [ID_W-1:0] mem [NUM_IDS];
  logic [ID_W-1:0] head_q, head_d;
  logic [ID_W-1:0] tail_q, tail_d;
  logic [ID_W:0]   count_q, count_d;

  // Pointers wrap naturally because NUM_IDS is a power of two.
  always_comb begin
    head_d  = head_q + ID_W'(rd_en);
    tail_d  = tail_q + ID_W'(wr_en);
    count_d = count_q + (ID_W+1)'(wr_en) - (ID_W+1)'(rd_en);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail_q] <= wr_data;
    end
  end

  assign rd_data = (count_q != '0) ? mem[head_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/rayid_pool_ctrl.sv
// Owner of the shader rayID pool.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of rayid_pool_ctrl_if (primary/shadow allocation,
//              round-robin release from NUM_REL sources, pool status)
module rayid_pool_ctrl
  import rayid_pool_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IDS        = NUM_RAYIDS,
  parameter int unsigned ID_W           = RAYID_W,
  parameter int unsigned SHADOW_RESERVE = SHADOW_RESERVE_DEFAULT,
  parameter int unsigned NUM_REL        = NUM_REL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  rayid_pool_ctrl_if.slave  bus
);

  localparam int unsigned   REL_W       = (NUM_REL > 1) ? $clog2(NUM_REL) : 1;
  localparam logic [ID_W:0] RESERVE_CNT = (ID_W+1)'(SHADOW_RESERVE);

  pool_state_e        state_q, state_d;
  logic [ID_W-1:0]    init_cnt_q, init_cnt_d;
  logic [NUM_IDS-1:0] in_use_q, in_use_d;
  logic [REL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               err_q, err_d;

  logic               run;
  logic [ID_W-1:0]    head;
  logic [ID_W:0]      count;
  logic               prim_gnt, shd_gnt, grant;
  logic               rel_any;
  logic [REL_W-1:0]   rel_win;
  logic [REL_W-1:0]   rel_idx;
  logic [ID_W-1:0]    rel_sel;
  logic               good_rel, bad_rel;
  logic [NUM_REL-1:0] rel_stall;
  logic               fl_wr_en;
  logic [ID_W-1:0]    fl_wr_data;

  rayid_freelist #(
    .NUM_IDS (NUM_IDS),
    .ID_W    (ID_W)
  ) u_freelist (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fl_wr_en),
    .wr_data (fl_wr_data),
    .rd_en   (grant),
    .rd_data (head),
    .count   (count)
  );

  always_comb begin
    run      = (state_q == RUN);
    shd_gnt  = run & bus.shd_req & (count != '0);
    prim_gnt = run & bus.prim_req & ~bus.shd_req & (count > RESERVE_CNT);
    grant    = prim_gnt | shd_gnt;

    // Round-robin search starting at the priority pointer.
    rel_any = 1'b0;
    rel_win = '0;
    rel_idx = '0;
    for (int unsigned k = 0; k < NUM_REL; k++) begin
      rel_idx = REL_W'((32'(rr_ptr_q) + k) % NUM_REL);
      if (!rel_any && bus.rel_valid[rel_idx]) begin
        rel_any = 1'b1;
        rel_win = rel_idx;
      end
    end

    rel_sel  = bus.rel_id[rel_win];
    // A release of an ID that is not outstanding is consumed but dropped.
    good_rel = run & rel_any & in_use_q[rel_sel];
    bad_rel  = run & rel_any & ~in_use_q[rel_sel];

    for (int unsigned i = 0; i < NUM_REL; i++) begin
      if (!run) begin
        rel_stall[i] = 1'b1;
      end else begin
        rel_stall[i] = bus.rel_valid[i] & ~(rel_any && (rel_win == REL_W'(i)));
      end
    end

    fl_wr_en   = run ? good_rel : 1'b1;
    fl_wr_data = run ? rel_sel : init_cnt_q;

    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    in_use_d   = in_use_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q | bad_rel;

    if (!run) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == ID_W'(NUM_IDS - 1)) begin
        state_d    = RUN;
        init_cnt_d = '0;
      end
    end

    if (run && rel_any) begin
      rr_ptr_d = (rel_win == REL_W'(NUM_REL - 1)) ? '0 : rel_win + 1'b1;
    end

    if (good_rel) begin
      in_use_d[rel_sel] = 1'b0;
    end
    if (grant) begin
      in_use_d[head] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      in_use_q   <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      in_use_q   <= in_use_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
    end
  end

  assign bus.prim_gnt     = prim_gnt;
  assign bus.shd_gnt      = shd_gnt;
  assign bus.prim_id      = head;
  assign bus.shd_id       = head;
  assign bus.rel_stall    = rel_stall;
  assign bus.free_count   = count;
  assign bus.init_done    = (state_q == RUN);
  assign bus.err_bad_free = err_q;

endmodule

// File: tb/tb_rayid_pool_ctrl.sv
module tb_rayid_pool_ctrl;
  import rayid_pool_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  rayid_pool_ctrl_if bus ();

  rayid_pool_ctrl #(
    .NUM_IDS        (512),
    .ID_W           (9),
    .SHADOW_RESERVE (32),
    .NUM_REL        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    bus.prim_req  = 1'b0;
    bus.shd_req   = 1'b0;
    bus.rel_valid = '0;
    bus.rel_id    = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (bus.init_done !== 1'b1 && cycles < 600) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cycles;
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.prim_req  = 1'b1;
    bus.shd_req   = 1'b1;
    bus.rel_valid = 4'hF;
    #1;
    tests_run++; if (bus.prim_gnt !== 1'b0) begin tests_failed++; $display("FAIL rst_prim_gnt: got %0b expected 0", bus.prim_gnt); end
    tests_run++; if (bus.shd_gnt !== 1'b0) begin tests_failed++; $display("FAIL rst_shd_gnt: got %0b expected 0", bus.shd_gnt); end
    tests_run++; if (bus.prim_id !== 9'd0) begin tests_failed++; $display("FAIL rst_prim_id: got %0d expected 0", bus.prim_id); end
    tests_run++; if (bus.shd_id !== 9'd0) begin tests_failed++; $display("FAIL rst_shd_id: got %0d expected 0", bus.shd_id); end
    tests_run++; if (bus.rel_stall !== 4'hF) begin tests_failed++; $display("FAIL rst_rel_stall: got %b expected 1111", bus.rel_stall); end
    tests_run++; if (bus.free_count !== 10'd0) begin tests_failed++; $display("FAIL rst_free_count: got %0d expected 0", bus.free_count); end
    tests_run++; if (bus.init_done !== 1'b0) begin tests_failed++; $display("FAIL rst_init_done: got %0b expected 0", bus.init_done); end
    tests_run++; if (bus.err_bad_free !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %0b expected 0", bus.err_bad_free); end

    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++; if (bus.shd_gnt !== 1'b0) begin tests_failed++; $display("FAIL init_shd_gnt: got %0b expected 0", bus.shd_gnt); end
    tests_run++; if (bus.rel_stall !== 4'hF) begin tests_failed++; $display("FAIL init_rel_stall: got %b expected 1111", bus.rel_stall); end

    cycles = 0;
    while (bus.init_done !== 1'b1 && cycles < 600) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        tests_run++; if (bus.free_count !== 10'd1) begin tests_failed++; $display("FAIL init_count_up: got %0d expected 1", bus.free_count); end
        clear_inputs();
      end
    end
    tests_run++; if (cycles !== 512) begin tests_failed++; $display("FAIL init_cycles: got %0d expected 512", cycles); end
    tests_run++; if (bus.free_count !== 10'd512) begin tests_failed++; $display("FAIL init_free_count: got %0d expected 512", bus.free_count); end

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.shd_req = 1'b1;
      #1;
      tests_run++; if (bus.shd_gnt !== 1'b1) begin tests_failed++; $display("FAIL first_shd_gnt%0d: got %0b expected 1", k, bus.shd_gnt); end
      tests_run++; if (bus.shd_id !== 9'(k)) begin tests_failed++; $display("FAIL first_shd_id%0d: got %0d expected %0d", k, bus.shd_id, k); end
      tests_run++; if (bus.prim_id !== 9'(k)) begin tests_failed++; $display("FAIL first_prim_id%0d: got %0d expected %0d", k, bus.prim_id, k); end
    end
    @(negedge clk);
    bus.shd_req = 1'b0;
    #1;
    tests_run++; if (bus.free_count !== 10'd509) begin tests_failed++; $display("FAIL first_free_count: got %0d expected 509", bus.free_count); end
  endtask

  // Pool holds 3..511; IDs 0..2 outstanding.
  task automatic test_bad_free();
    for (int k = 3; k < 8; k++) begin
      @(negedge clk);
      bus.shd_req = 1'b1;
      #1;
      tests_run++; if (bus.shd_id !== 9'(k)) begin tests_failed++; $display("FAIL bf_grant_id%0d: got %0d expected %0d", k, bus.shd_id, k); end
    end
    @(negedge clk);
    bus.shd_req   = 1'b0;
    bus.rel_valid = 4'b0010;
    bus.rel_id[1] = 9'd7;
    #1;
    tests_run++; if (bus.free_count !== 10'd504) begin tests_failed++; $display("FAIL bf_count_before: got %0d expected 504", bus.free_count); end
    tests_run++; if (bus.rel_stall !== 4'b0000) begin tests_failed++; $display("FAIL bf_stall1: got %b expected 0000", bus.rel_stall); end
    @(negedge clk);
    #1;
    tests_run++; if (bus.free_count !== 10'd505) begin tests_failed++; $display("FAIL bf_count_first: got %0d expected 505", bus.free_count); end
    tests_run++; if (bus.err_bad_free !== 1'b0) begin tests_failed++; $display("FAIL bf_err_first: got %0b expected 0", bus.err_bad_free); end
    tests_run++; if (bus.rel_stall !== 4'b0000) begin tests_failed++; $display("FAIL bf_stall2: got %b expected 0000", bus.rel_stall); end
    @(negedge clk);
    bus.rel_valid = '0;
    #1;
    tests_run++; if (bus.err_bad_free !== 1'b1) begin tests_failed++; $display("FAIL bf_err_second: got %0b expected 1", bus.err_bad_free); end
    tests_run++; if (bus.free_count !== 10'd505) begin tests_failed++; $display("FAIL bf_count_second: got %0d expected 505", bus.free_count); end
  endtask

  task automatic test_both_req();
    int cycles;
    int n;
    apply_reset();
    wait_init(cycles);
    tests_run++; if (bus.init_done !== 1'b1) begin tests_failed++; $display("FAIL both_init: got %0b expected 1", bus.init_done); end
    n = 0;
    repeat (412) begin
      @(negedge clk);
      bus.prim_req = 1'b1;
      #1;
      if (bus.prim_gnt === 1'b1) n++;
    end
    @(negedge clk);
    bus.shd_req = 1'b1;
    #1;
    tests_run++; if (n !== 412) begin tests_failed++; $display("FAIL both_prim_grants: got %0d expected 412", n); end
    tests_run++; if (bus.free_count !== 10'd100) begin tests_failed++; $display("FAIL both_count100: got %0d expected 100", bus.free_count); end
    tests_run++; if (bus.shd_gnt !== 1'b1) begin tests_failed++; $display("FAIL both_shd_gnt: got %0b expected 1", bus.shd_gnt); end
    tests_run++; if (bus.prim_gnt !== 1'b0) begin tests_failed++; $display("FAIL both_prim_gnt: got %0b expected 0", bus.prim_gnt); end
    tests_run++; if (bus.shd_id !== 9'd412) begin tests_failed++; $display("FAIL both_shd_id: got %0d expected 412", bus.shd_id); end
    @(negedge clk);
    clear_inputs();
    #1;
    tests_run++; if (bus.free_count !== 10'd99) begin tests_failed++; $display("FAIL both_count99: got %0d expected 99", bus.free_count); end
  endtask

  task automatic test_drain();
    int cycles;
    int n, m;
    logic [8:0] first_id, last_id;
    logic saw33, prio_viol;
    apply_reset();
    wait_init(cycles);
    tests_run++; if (bus.init_done !== 1'b1) begin tests_failed++; $display("FAIL drain_init: got %0b expected 1", bus.init_done); end
    n = 0; saw33 = 1'b0; first_id = '0; last_id = '0;
    @(negedge clk);
    bus.prim_req = 1'b1;
    for (int c = 0; c < 600; c++) begin
      #1;
      if (bus.prim_gnt !== 1'b1) break;
      if (n == 0) first_id = bus.prim_id;
      last_id = bus.prim_id;
      if (bus.free_count === 10'd33) saw33 = 1'b1;
      n++;
      @(negedge clk);
    end
    tests_run++; if (n !== 480) begin tests_failed++; $display("FAIL drain_prim_grants: got %0d expected 480", n); end
    tests_run++; if (bus.free_count !== 10'd32) begin tests_failed++; $display("FAIL drain_reserve_count: got %0d expected 32", bus.free_count); end
    tests_run++; if (bus.prim_gnt !== 1'b0) begin tests_failed++; $display("FAIL drain_prim_at_reserve: got %0b expected 0", bus.prim_gnt); end
    tests_run++; if (saw33 !== 1'b1) begin tests_failed++; $display("FAIL drain_grant_at_33: got %0b expected 1", saw33); end
    tests_run++; if (first_id !== 9'd0) begin tests_failed++; $display("FAIL drain_first_id: got %0d expected 0", first_id); end
    tests_run++; if (last_id !== 9'd479) begin tests_failed++; $display("FAIL drain_last_id: got %0d expected 479", last_id); end

    m = 0; prio_viol = 1'b0;
    bus.shd_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bus.shd_gnt !== 1'b1) break;
      if (bus.prim_gnt !== 1'b0) prio_viol = 1'b1;
      if (m == 0) first_id = bus.shd_id;
      last_id = bus.shd_id;
      m++;
      @(negedge clk);
    end
    tests_run++; if (m !== 32) begin tests_failed++; $display("FAIL drain_shd_grants: got %0d expected 32", m); end
    tests_run++; if (prio_viol !== 1'b0) begin tests_failed++; $display("FAIL drain_shd_priority: got %0b expected 0", prio_viol); end
    tests_run++; if (first_id !== 9'd480) begin tests_failed++; $display("FAIL drain_shd_first: got %0d expected 480", first_id); end
    tests_run++; if (last_id !== 9'd511) begin tests_failed++; $display("FAIL drain_shd_last: got %0d expected 511", last_id); end
    tests_run++; if (bus.free_count !== 10'd0) begin tests_failed++; $display("FAIL drain_empty_count: got %0d expected 0", bus.free_count); end
    clear_inputs();
  endtask

  // Pool empty, all IDs outstanding, rr pointer at 0.
  task automatic test_empty_release();
    @(negedge clk);
    bus.shd_req   = 1'b1;
    bus.rel_valid = 4'b1000;
    bus.rel_id[3] = 9'd5;
    #1;
    tests_run++; if (bus.shd_gnt !== 1'b0) begin tests_failed++; $display("FAIL empty_shd_gnt: got %0b expected 0", bus.shd_gnt); end
    tests_run++; if (bus.rel_stall !== 4'b0000) begin tests_failed++; $display("FAIL empty_rel_stall: got %b expected 0000", bus.rel_stall); end
    @(negedge clk);
    bus.rel_valid = '0;
    #1;
    tests_run++; if (bus.free_count !== 10'd1) begin tests_failed++; $display("FAIL empty_count1: got %0d expected 1", bus.free_count); end
    tests_run++; if (bus.shd_gnt !== 1'b1) begin tests_failed++; $display("FAIL empty_regrant: got %0b expected 1", bus.shd_gnt); end
    tests_run++; if (bus.shd_id !== 9'd5) begin tests_failed++; $display("FAIL empty_regrant_id: got %0d expected 5", bus.shd_id); end
    @(negedge clk);
    bus.shd_req = 1'b0;
    #1;
    tests_run++; if (bus.free_count !== 10'd0) begin tests_failed++; $display("FAIL empty_count0: got %0d expected 0", bus.free_count); end
  endtask

  // Source 3 won last, so the pointer is back at 0.
  task automatic test_release_rr();
    logic [8:0] cur_id [4];
    logic [3:0] exp_stall;
    int w;
    for (int s = 0; s < 4; s++) cur_id[s] = 9'(200 + 16 * s);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.rel_valid = 4'hF;
      for (int s = 0; s < 4; s++) bus.rel_id[s] = cur_id[s];
      #1;
      w = c % 4;
      exp_stall = 4'hF & ~(4'b0001 << w);
      tests_run++; if (bus.rel_stall !== exp_stall) begin tests_failed++; $display("FAIL rr_stall_c%0d: got %b expected %b", c, bus.rel_stall, exp_stall); end
      cur_id[w] = cur_id[w] + 9'd1;
    end
    @(negedge clk);
    bus.rel_valid = '0;
    #1;
    tests_run++; if (bus.free_count !== 10'd8) begin tests_failed++; $display("FAIL rr_free_count: got %0d expected 8", bus.free_count); end
    tests_run++; if (bus.err_bad_free !== 1'b0) begin tests_failed++; $display("FAIL rr_err: got %0b expected 0", bus.err_bad_free); end
  endtask

  // Free list now holds 200,216,232,248,201,217,233,249 in that order.
  task automatic test_fifo_order();
    logic [8:0] exp_ids [4];
    exp_ids[0] = 9'd200; exp_ids[1] = 9'd216; exp_ids[2] = 9'd232; exp_ids[3] = 9'd248;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.shd_req = 1'b1;
      #1;
      tests_run++; if (bus.shd_id !== exp_ids[k]) begin tests_failed++; $display("FAIL fifo_id%0d: got %0d expected %0d", k, bus.shd_id, exp_ids[k]); end
    end
    @(negedge clk);
    bus.shd_req = 1'b0;
    #1;
    tests_run++; if (bus.free_count !== 10'd4) begin tests_failed++; $display("FAIL fifo_count: got %0d expected 4", bus.free_count); end
  endtask

  task automatic test_reset_mid();
    int cycles;
    apply_reset();
    wait_init(cycles);
    tests_run++; if (bus.init_done !== 1'b1) begin tests_failed++; $display("FAIL mid_init: got %0b expected 1", bus.init_done); end
    @(negedge clk);
    bus.rel_valid = 4'b0001;
    bus.rel_id[0] = 9'd300;
    #1;
    tests_run++; if (bus.rel_stall !== 4'b0000) begin tests_failed++; $display("FAIL mid_bad_stall: got %b expected 0000", bus.rel_stall); end
    @(negedge clk);
    bus.rel_valid = '0;
    #1;
    tests_run++; if (bus.err_bad_free !== 1'b1) begin tests_failed++; $display("FAIL mid_err_set: got %0b expected 1", bus.err_bad_free); end
    tests_run++; if (bus.free_count !== 10'd512) begin tests_failed++; $display("FAIL mid_count_bad: got %0d expected 512", bus.free_count); end
    @(negedge clk);
    bus.prim_req = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests_run++; if (bus.prim_gnt !== 1'b0) begin tests_failed++; $display("FAIL mid_prim_gnt: got %0b expected 0", bus.prim_gnt); end
    tests_run++; if (bus.shd_gnt !== 1'b0) begin tests_failed++; $display("FAIL mid_shd_gnt: got %0b expected 0", bus.shd_gnt); end
    tests_run++; if (bus.prim_id !== 9'd0) begin tests_failed++; $display("FAIL mid_prim_id: got %0d expected 0", bus.prim_id); end
    tests_run++; if (bus.rel_stall !== 4'hF) begin tests_failed++; $display("FAIL mid_rel_stall: got %b expected 1111", bus.rel_stall); end
    tests_run++; if (bus.free_count !== 10'd0) begin tests_failed++; $display("FAIL mid_free_count: got %0d expected 0", bus.free_count); end
    tests_run++; if (bus.init_done !== 1'b0) begin tests_failed++; $display("FAIL mid_init_done: got %0b expected 0", bus.init_done); end
    tests_run++; if (bus.err_bad_free !== 1'b0) begin tests_failed++; $display("FAIL mid_err_clear: got %0b expected 0", bus.err_bad_free); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    wait_init(cycles);
    tests_run++; if (cycles !== 512) begin tests_failed++; $display("FAIL mid_reinit_cycles: got %0d expected 512", cycles); end
    tests_run++; if (bus.free_count !== 10'd512) begin tests_failed++; $display("FAIL mid_reinit_count: got %0d expected 512", bus.free_count); end
    @(negedge clk);
    bus.shd_req = 1'b1;
    #1;
    tests_run++; if (bus.shd_id !== 9'd0) begin tests_failed++; $display("FAIL mid_reinit_id: got %0d expected 0", bus.shd_id); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_bad_free();
    test_both_req();
    test_drain();
    test_empty_release();
    test_release_rr();
    test_fifo_order();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
